// File: rtl/stopwatch_pkg.sv
// Shared constants and the packed-BCD increment used by the stopwatch counters.
package stopwatch_pkg;

  localparam int             BCD_W            = 8;
  localparam logic [BCD_W-1:0] SEC_MAX        = 8'h59;
  localparam logic [BCD_W-1:0] MIN_MAX        = 8'h59;
  localparam int             TICK_DIV_DEFAULT = 25000000;

  // Units 9 rolls into the tens digit; the caller handles the modulus wrap.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] q);
    logic [BCD_W-1:0] r;
    if (q[3:0] == 4'd9) begin
      r = {q[7:4] + 4'd1, 4'd0};
    end else begin
      r = {q[7:4], q[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_if.sv
// Button inputs and packed-BCD time outputs of the stopwatch, as seen by the time printer.
interface stopwatch_bcd_if;
  import stopwatch_pkg::*;

  logic             ss;
  logic             clr;
  logic [BCD_W-1:0] th;
  logic [BCD_W-1:0] tm;
  logic [BCD_W-1:0] ts;
  logic             running;
  logic             tick;

  modport master (
    output ss, clr,
    input  th, tm, ts, running, tick
  );

  modport slave (
    input  ss, clr,
    output th, tm, ts, running, tick
  );

endinterface

// File: rtl/bcd2_counter.sv
// Two-digit packed-BCD counter wrapping at MAX; carry is combinational so a chain settles in one edge.
module bcd2_counter
  import stopwatch_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = SEC_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  assign carry = inc && (q == MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= carry ? '0 : bcd_inc(q);
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// Elapsed-time stopwatch: synchronised start/stop and clear, prescaler, and hh:mm:ss BCD chain.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int               TICK_DIV = TICK_DIV_DEFAULT,
  parameter logic [BCD_W-1:0] HOUR_MAX = 8'h99
) (
  input  logic          clk,
  input  logic          reset,
  stopwatch_bcd_if.slave bus
);

  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic             ss_p0, ss_p1, ss_p2, ss_rise_p3;
  logic             clr_p0, clr_p1;
  logic             run;
  logic             tick_r;
  logic [PRE_W-1:0] pre;
  logic             clear;
  logic             inc_sec;
  logic             sec_carry, min_carry, hour_carry_unused;
  logic [BCD_W-1:0] th_q, tm_q, ts_q;

  // Clear is judged against the run state before any toggle on the same edge.
  assign clear   = clr_p1 && !run;
  assign inc_sec = run && (pre == PRE_LAST);

  // Synchroniser stages, then registered rising-edge pulse for ss.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_p0      <= 1'b0;
      ss_p1      <= 1'b0;
      ss_p2      <= 1'b0;
      ss_rise_p3 <= 1'b0;
      clr_p0     <= 1'b0;
      clr_p1     <= 1'b0;
    end else begin
      ss_p0      <= bus.ss;
      ss_p1      <= ss_p0;
      ss_p2      <= ss_p1;
      ss_rise_p3 <= ss_p1 && !ss_p2;
      clr_p0     <= bus.clr;
      clr_p1     <= clr_p0;
    end
  end

  // Run flag, prescaler and tick; prescaler holds while stopped to keep the fraction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run    <= 1'b0;
      tick_r <= 1'b0;
      pre    <= '0;
    end else begin
      if (ss_rise_p3) begin
        run <= !run;
      end
      tick_r <= inc_sec;
      if (clear) begin
        pre <= '0;
      end else if (run) begin
        pre <= inc_sec ? '0 : pre + 1'b1;
      end
    end
  end

  bcd2_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (inc_sec),
    .q     (ts_q),
    .carry (sec_carry)
  );

  bcd2_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (sec_carry),
    .q     (tm_q),
    .carry (min_carry)
  );

  bcd2_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (min_carry),
    .q     (th_q),
    .carry (hour_carry_unused)
  );

  assign bus.th      = th_q;
  assign bus.tm      = tm_q;
  assign bus.ts      = ts_q;
  assign bus.running = run;
  assign bus.tick    = tick_r;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with TICK_DIV=4; a second instance with HOUR_MAX=01 shows the hour wrap.
module tb_stopwatch_bcd;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stopwatch_bcd_if sw_if ();
  stopwatch_bcd_if sw2_if ();

  assign sw2_if.ss  = sw_if.ss;
  assign sw2_if.clr = sw_if.clr;

  stopwatch_bcd #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sw_if.slave)
  );

  stopwatch_bcd #(.TICK_DIV(4), .HOUR_MAX(8'h01)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (sw2_if.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int r_edge   = 0;

  typedef struct {
    int         adv;
    logic       clr;
    logic [7:0] ts;
    logic       tick;
  } vec_t;

  vec_t vecs [14];

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) begin
        @(posedge clk);
        cyc++;
      end
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] hms(input int k, input int hmod);
    return {bcd((k / 3600) % hmod), bcd((k / 60) % 60), bcd(k % 60)};
  endfunction

  task automatic chk_time(input string name, input logic [23:0] exp);
    chk(name, {8'h00, sw_if.th, sw_if.tm, sw_if.ts}, {8'h00, exp});
  endtask

  task automatic chk_time2(input string name, input logic [23:0] exp);
    chk(name, {8'h00, sw2_if.th, sw2_if.tm, sw2_if.ts}, {8'h00, exp});
  endtask

  task automatic goto_sec(input int k);
    step(r_edge + 4 * k - cyc);
  endtask

  initial begin
    vecs[0]  = '{1, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{3, 1'b0, 8'h01, 1'b1};
    vecs[2]  = '{1, 1'b0, 8'h01, 1'b0};
    vecs[3]  = '{3, 1'b0, 8'h02, 1'b1};
    vecs[4]  = '{4, 1'b0, 8'h03, 1'b1};
    vecs[5]  = '{4, 1'b0, 8'h04, 1'b1};
    vecs[6]  = '{4, 1'b1, 8'h05, 1'b1};
    vecs[7]  = '{4, 1'b1, 8'h06, 1'b1};
    vecs[8]  = '{2, 1'b1, 8'h06, 1'b0};
    vecs[9]  = '{2, 1'b0, 8'h07, 1'b1};
    vecs[10] = '{4, 1'b0, 8'h08, 1'b1};
    vecs[11] = '{4, 1'b0, 8'h09, 1'b1};
    vecs[12] = '{1, 1'b0, 8'h09, 1'b0};
    vecs[13] = '{3, 1'b0, 8'h10, 1'b1};

    sw_if.ss  = 1'b0;
    sw_if.clr = 1'b0;

    // Reset state
    step(2);
    chk_time("reset_time", 24'h000000);
    chk("reset_running", sw_if.running, 1'b0);
    chk("reset_tick", sw_if.tick, 1'b0);
    reset = 1'b1;
    step(2);

    // Start: running appears three edges after the sampling edge
    sw_if.ss = 1'b1;
    step(1);
    chk("start_lat_n0", sw_if.running, 1'b0);
    step(1);
    sw_if.ss = 1'b0;
    chk("start_lat_n1", sw_if.running, 1'b0);
    step(1);
    chk("start_lat_n2", sw_if.running, 1'b0);
    step(1);
    chk("start_lat_n3", sw_if.running, 1'b1);
    r_edge = cyc;

    // Tick cadence and BCD units rollover; clr while running is ignored
    for (int i = 0; i < 14; i++) begin
      sw_if.clr = vecs[i].clr;
      step(vecs[i].adv);
      chk($sformatf("vec%0d_ts", i), sw_if.ts, vecs[i].ts);
      chk($sformatf("vec%0d_tick", i), sw_if.tick, vecs[i].tick);
      chk($sformatf("vec%0d_running", i), sw_if.running, 1'b1);
    end

    // Carry chain
    goto_sec(59);
    chk_time("t59", hms(59, 100));
    goto_sec(60);
    chk_time("t60", 24'h000100);
    chk("t60_tick", sw_if.tick, 1'b1);
    goto_sec(3599);
    chk_time("t3599", 24'h005959);
    goto_sec(3600);
    chk_time("t3600", 24'h010000);
    chk_time2("t3600_h1", 24'h010000);
    goto_sec(7199);
    chk_time("t7199", 24'h015959);
    chk_time2("t7199_h1", 24'h015959);
    goto_sec(7200);
    chk_time("t7200", 24'h020000);
    chk_time2("t7200_h1_wrap", 24'h000000);
    chk("t7200_h1_tick", sw2_if.tick, 1'b1);
    step(1);
    chk("t7200_tick_single", sw_if.tick, 1'b0);
    chk("t7200_h1_tick_single", sw2_if.tick, 1'b0);

    // Stop with prescaler at 2 while holding ss for 100 cycles
    step(1);
    sw_if.ss = 1'b1;
    step(3);
    chk("stop_lat_n2", sw_if.running, 1'b1);
    step(1);
    chk("stop_lat_n3", sw_if.running, 1'b0);
    chk_time("stop_time", hms(7201, 100));
    step(96);
    chk("ss_held_running", sw_if.running, 1'b0);
    sw_if.ss = 1'b0;
    step(20);
    chk("stopped_running", sw_if.running, 1'b0);
    chk("stopped_tick", sw_if.tick, 1'b0);
    chk_time("stopped_time", hms(7201, 100));

    // Restart: the held fraction yields a tick two cycles after running
    sw_if.ss = 1'b1;
    step(3);
    chk("restart_lat_n2", sw_if.running, 1'b0);
    sw_if.ss = 1'b0;
    step(1);
    chk("restart_running", sw_if.running, 1'b1);
    chk("restart_ts", sw_if.ts, 8'h01);
    step(1);
    chk("restart_tick_early", sw_if.tick, 1'b0);
    step(1);
    chk("restart_tick", sw_if.tick, 1'b1);
    chk("restart_ts_inc", sw_if.ts, 8'h02);

    // Stop edge with clr: clr ignored, coincident tick completes
    sw_if.ss  = 1'b1;
    sw_if.clr = 1'b1;
    step(2);
    sw_if.ss  = 1'b0;
    sw_if.clr = 1'b0;
    step(1);
    chk("stopclr_running_pre", sw_if.running, 1'b1);
    chk("stopclr_ts_pre", sw_if.ts, 8'h02);
    step(1);
    chk("stopclr_running", sw_if.running, 1'b0);
    chk("stopclr_tick", sw_if.tick, 1'b1);
    chk("stopclr_ts", sw_if.ts, 8'h03);
    step(1);
    chk("stopclr_tick_end", sw_if.tick, 1'b0);
    chk_time("stopclr_time", hms(7203, 100));

    // clr while stopped, level-held
    sw_if.clr = 1'b1;
    step(2);
    chk("clr_not_yet", sw_if.ts, 8'h03);
    step(1);
    chk_time("clr_zero", 24'h000000);
    step(10);
    chk_time("clr_held_zero", 24'h000000);
    chk("clr_held_running", sw_if.running, 1'b0);
    sw_if.clr = 1'b0;
    step(3);

    // Count a little, then stop with nonzero time
    sw_if.ss = 1'b1;
    step(2);
    sw_if.ss = 1'b0;
    step(2);
    chk("run2_running", sw_if.running, 1'b1);
    step(8);
    chk("run2_ts", sw_if.ts, 8'h02);
    sw_if.ss = 1'b1;
    step(2);
    sw_if.ss = 1'b0;
    step(2);
    chk("run2_stopped", sw_if.running, 1'b0);
    chk("run2_stop_ts", sw_if.ts, 8'h03);
    step(3);

    // Start edge with clr while stopped restarts from zero
    sw_if.ss  = 1'b1;
    sw_if.clr = 1'b1;
    step(2);
    sw_if.ss  = 1'b0;
    sw_if.clr = 1'b0;
    step(1);
    chk_time("startclr_zero_pre", 24'h000000);
    chk("startclr_running_pre", sw_if.running, 1'b0);
    step(1);
    chk("startclr_running", sw_if.running, 1'b1);
    chk_time("startclr_zero", 24'h000000);
    step(4);
    chk("startclr_tick", sw_if.tick, 1'b1);
    chk("startclr_ts", sw_if.ts, 8'h01);
    step(1);

    // Asynchronous reset mid-count, then restart latency
    #3;
    reset = 1'b0;
    #1;
    chk_time("async_reset_time", 24'h000000);
    chk("async_reset_running", sw_if.running, 1'b0);
    chk("async_reset_tick", sw_if.tick, 1'b0);
    #2;
    reset = 1'b1;
    sw_if.ss = 1'b1;
    step(3);
    chk("post_reset_lat_n2", sw_if.running, 1'b0);
    sw_if.ss = 1'b0;
    step(1);
    chk("post_reset_running", sw_if.running, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
